// File: rtl/serial_command_decoder.sv
// Byte-level command decoder for the phased-array serial link: parses read/write/update
// frames, keeps shadow and active delay banks, and drives the read-back byte.
module serial_command_decoder #(
   parameter int NUM_CH  = 16,
   parameter int DELAY_W = 12,
   parameter int TIMEOUT = 1000
) (
   input  logic                      CLK,
   input  logic                      res_n,
   input  logic [7:0]                recievedData,
   input  logic                      recieved,
   output logic [7:0]                sendData,
   output logic [NUM_CH*DELAY_W-1:0] delays,
   output logic                      update,
   output logic                      frame_err,
   output logic [2:0]                dbg_state
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WR_HI = 3'd1,
      S_WR_LO = 3'd2,
      S_RD_1  = 3'd3,
      S_RD_2  = 3'd4,
      S_RD_3  = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic                sync1_q, sync2_q, edge_q;
   logic [5:0]          addr_q, addr_d;
   logic [7:0]          hi_q, hi_d;
   logic                upd_pend_q, upd_pend_d;
   logic                load_q, load_d;
   logic [7:0]          send_q, send_d;
   logic                update_q, frame_err_q, frame_err_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DELAY_W-1:0]  shadow_q [NUM_CH];
   logic [DELAY_W-1:0]  active_q [NUM_CH];

   logic                byte_v, wr_en, load_now;
   logic [5:0]          sel_addr;
   logic [DELAY_W-1:0]  rd_word, wdata;
   logic [15:0]         rd_ext, wword;

   // Byte handshake: recievedData is valid whenever recieved is high; one byte is taken
   // per synchronized rising edge of recieved, there is no back-pressure towards the slave.
   assign byte_v = sync2_q & ~edge_q;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      hi_d        = hi_q;
      upd_pend_d  = upd_pend_q;
      send_d      = send_q;
      load_d      = 1'b0;
      load_now    = load_q;
      frame_err_d = 1'b0;
      wr_en       = 1'b0;
      cnt_d       = (cnt_q == TO_MAX) ? cnt_q : cnt_q + 1'b1;
      sel_addr    = (state_q == S_IDLE) ? recievedData[5:0] : addr_q;
      rd_word     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel_addr == 6'(i)) rd_word = shadow_q[i];
      end
      rd_ext = '0;
      rd_ext[DELAY_W-1:0] = rd_word;
      wword = {hi_q, recievedData};
      wdata = wword[DELAY_W-1:0];

      if (byte_v) begin
         cnt_d = '0;
         case (state_q)
            S_IDLE: begin
               addr_d = recievedData[5:0];
               send_d = 8'h00;
               case (recievedData[7:6])
                  2'b00: begin
                     state_d = S_RD_1;
                     send_d  = rd_ext[15:8];
                  end
                  2'b01: load_now = 1'b1;
                  default: begin
                     state_d    = S_WR_HI;
                     upd_pend_d = recievedData[6];
                  end
               endcase
            end
            S_WR_HI: begin
               hi_d    = recievedData;
               state_d = S_WR_LO;
            end
            S_WR_LO: begin
               wr_en      = 1'b1;
               load_d     = upd_pend_q;
               upd_pend_d = 1'b0;
               state_d    = S_IDLE;
            end
            S_RD_1: begin
               send_d  = rd_ext[7:0];
               state_d = S_RD_2;
            end
            S_RD_2: begin
               send_d  = 8'h00;
               state_d = S_RD_3;
            end
            default: begin
               send_d  = 8'h00;
               state_d = S_IDLE;
            end
         endcase
      end else if (state_q != S_IDLE && cnt_q == TO_MAX) begin
         // Abandoned partial frame: drop any pending write/update.
         state_d     = S_IDLE;
         send_d      = 8'h00;
         upd_pend_d  = 1'b0;
         frame_err_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge res_n) begin
      if (!res_n) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         edge_q      <= 1'b0;
         addr_q      <= '0;
         hi_q        <= '0;
         upd_pend_q  <= 1'b0;
         load_q      <= 1'b0;
         send_q      <= '0;
         update_q    <= 1'b0;
         frame_err_q <= 1'b0;
         cnt_q       <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         sync1_q     <= recieved;
         sync2_q     <= sync1_q;
         edge_q      <= sync2_q;
         addr_q      <= addr_d;
         hi_q        <= hi_d;
         upd_pend_q  <= upd_pend_d;
         load_q      <= load_d;
         send_q      <= send_d;
         update_q    <= load_now;
         frame_err_q <= frame_err_d;
         cnt_q       <= cnt_d;
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && addr_q == 6'(i)) shadow_q[i] <= wdata;
            if (load_now) active_q[i] <= shadow_q[i];
         end
      end
   end

   always_comb begin
      delays = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         delays[i*DELAY_W +: DELAY_W] = active_q[i];
      end
   end

   assign sendData  = send_q;
   assign update    = update_q;
   assign frame_err = frame_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_command_decoder.sv
// Directed bench for serial_command_decoder: a vector table of command bytes with
// expected read-back/update/delay values, plus cycle-level corner-case sequences.
module tb_serial_command_decoder;
  localparam int NUM_CH  = 16;
  localparam int DELAY_W = 12;
  localparam int TIMEOUT = 60;

  logic                      CLK;
  logic                      res_n;
  logic [7:0]                recievedData;
  logic                      recieved;
  logic [7:0]                sendData;
  logic [NUM_CH*DELAY_W-1:0] delays;
  logic                      update;
  logic                      frame_err;
  logic [2:0]                dbg_state;

  serial_command_decoder #(
    .NUM_CH(NUM_CH), .DELAY_W(DELAY_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .res_n(res_n), .recievedData(recievedData), .recieved(recieved),
    .sendData(sendData), .delays(delays), .update(update), .frame_err(frame_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;
  int upd_cnt = 0;
  int fe_cnt = 0;

  always @(negedge CLK) begin
    if (update === 1'b1) upd_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  typedef struct {
    logic [7:0]  b;
    logic [7:0]  exp_send;
    int          exp_upd;
    int          ch;
    logic [11:0] exp_val;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int chan(input int i);
    return int'(delays[i*DELAY_W +: DELAY_W]);
  endfunction

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    recievedData = b;
    recieved = 1'b1;
    repeat (4) @(negedge CLK);
    recieved = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic timed_byte(input logic [7:0] b, output int first_upd);
    first_upd = 0;
    @(negedge CLK);
    recievedData = b;
    recieved = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (update === 1'b1 && first_upd == 0) first_upd = c;
      if (c == 4) recieved = 1'b0;
    end
  endtask

  initial begin
    int u0, f0, f;
    res_n = 1'b0;
    recieved = 1'b0;
    recievedData = 8'h00;

    vt.push_back('{8'h83, 8'h00, 0,  3, 12'h000});
    vt.push_back('{8'h0A, 8'h00, 0,  3, 12'h000});
    vt.push_back('{8'hBC, 8'h00, 0,  3, 12'h000});
    vt.push_back('{8'h43, 8'h00, 1,  3, 12'hABC});
    vt.push_back('{8'h03, 8'h0A, 0,  3, 12'hABC});
    vt.push_back('{8'h00, 8'hBC, 0,  3, 12'hABC});
    vt.push_back('{8'h00, 8'h00, 0,  3, 12'hABC});
    vt.push_back('{8'h00, 8'h00, 0,  3, 12'hABC});
    vt.push_back('{8'h80, 8'h00, 0,  0, 12'h000});
    vt.push_back('{8'h12, 8'h00, 0,  0, 12'h000});
    vt.push_back('{8'h34, 8'h00, 0,  0, 12'h000});
    vt.push_back('{8'h00, 8'h02, 0,  0, 12'h000});
    vt.push_back('{8'h00, 8'h34, 0,  0, 12'h000});
    vt.push_back('{8'h00, 8'h00, 0,  0, 12'h000});
    vt.push_back('{8'h00, 8'h00, 0,  0, 12'h000});
    vt.push_back('{8'h40, 8'h00, 1,  0, 12'h234});
    vt.push_back('{8'hBF, 8'h00, 0, 15, 12'h000});
    vt.push_back('{8'h0F, 8'h00, 0, 15, 12'h000});
    vt.push_back('{8'hFF, 8'h00, 0, 15, 12'h000});
    vt.push_back('{8'h40, 8'h00, 1, 15, 12'h000});
    vt.push_back('{8'h3F, 8'h00, 0,  3, 12'hABC});
    vt.push_back('{8'h00, 8'h00, 0,  3, 12'hABC});
    vt.push_back('{8'h00, 8'h00, 0,  0, 12'h234});
    vt.push_back('{8'h00, 8'h00, 0,  0, 12'h234});

    // reset state
    repeat (3) @(negedge CLK);
    check("rst_send", int'(sendData), 0);
    check("rst_delays_nonzero", int'(delays != '0), 0);
    check("rst_state", int'(dbg_state), 0);
    res_n = 1'b1;
    repeat (2 * TIMEOUT) @(negedge CLK);
    check("idle_update_cnt", upd_cnt, 0);
    check("idle_ferr_cnt", fe_cnt, 0);
    check("idle_delays_nonzero", int'(delays != '0), 0);

    // table
    foreach (vt[i]) begin
      u0 = upd_cnt;
      send_byte(vt[i].b);
      check($sformatf("v%0d_send", i), int'(sendData), int'(vt[i].exp_send));
      check($sformatf("v%0d_upd", i), upd_cnt - u0, vt[i].exp_upd);
      check($sformatf("v%0d_ch%0d", i, vt[i].ch), chan(vt[i].ch), int'(vt[i].exp_val));
    end
    check("table_ferr_cnt", fe_cnt, 0);

    // write+update: update one cycle after the lo-byte commit
    send_byte(8'hC5);
    send_byte(8'hFF);
    u0 = upd_cnt;
    timed_byte(8'h12, f);
    check("c5_upd_cycle", f, 4);
    check("c5_upd_once", upd_cnt - u0, 1);
    check("c5_ch5", chan(5), 'hF12);

    // timeout abort of a pending write, then an update-only command
    f0 = fe_cnt;
    send_byte(8'h87);
    repeat (TIMEOUT + 10) @(negedge CLK);
    check("to_ferr_once", fe_cnt - f0, 1);
    check("to_state_idle", int'(dbg_state), 0);
    check("to_send", int'(sendData), 0);
    u0 = upd_cnt;
    timed_byte(8'h45, f);
    check("upd_only_cycle", f, 3);
    check("upd_only_once", upd_cnt - u0, 1);
    check("to_ch7", chan(7), 0);

    // slow but in-time bytes keep the frame alive
    f0 = fe_cnt;
    u0 = upd_cnt;
    send_byte(8'hC7);
    repeat (TIMEOUT - 20) @(negedge CLK);
    send_byte(8'h01);
    repeat (TIMEOUT - 20) @(negedge CLK);
    send_byte(8'h23);
    check("slow_ferr", fe_cnt - f0, 0);
    check("slow_upd", upd_cnt - u0, 1);
    check("slow_ch7", chan(7), 'h123);

    // held-high recieved yields a single byte
    u0 = upd_cnt;
    @(negedge CLK);
    recievedData = 8'h40;
    recieved = 1'b1;
    repeat (20) @(negedge CLK);
    recieved = 1'b0;
    repeat (6) @(negedge CLK);
    check("held_high_upd", upd_cnt - u0, 1);

    // mid-frame reset
    send_byte(8'h83);
    send_byte(8'h01);
    @(negedge CLK);
    res_n = 1'b0;
    @(negedge CLK);
    check("mrst_delays_nonzero", int'(delays != '0), 0);
    check("mrst_send", int'(sendData), 0);
    check("mrst_state", int'(dbg_state), 0);
    check("mrst_update", int'(update), 0);
    check("mrst_ferr", int'(frame_err), 0);
    res_n = 1'b1;
    repeat (3) @(negedge CLK);
    u0 = upd_cnt;
    send_byte(8'hC2);
    send_byte(8'h01);
    send_byte(8'h23);
    check("post_rst_upd", upd_cnt - u0, 1);
    check("post_rst_ch2", chan(2), 'h123);
    check("post_rst_ch3", chan(3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_command_decoder.md
# serial_command_decoder

Byte-level command decoder sitting directly downstream of the SPI-style serial slave in the phased array controller. It consumes each received byte (`recievedData` / `recieved`), parses write, read and update frames, and maintains a shadow and an active bank of per-channel delay registers. It also drives the slave's `sendData` byte for read-back. The active bank feeds the per-channel delay generators.

## Interface
Parameters:
- `NUM_CH`, 16: number of delay channels, 1..64.
- `DELAY_W`, 12: delay register width, 9..16.
- `TIMEOUT`, 1000: CLK cycles without a byte before a partial frame is abandoned.

Ports:
- `CLK`  in  1  system clock; all logic is on its rising edge.
- `res_n`  in  1  reset, asynchronous, active-low.
- `recievedData`  in  8  byte from the serial slave. SCK domain; stable while `recieved` is high.
- `recieved`  in  1  byte-complete flag from the serial slave. SCK domain; high for about half an SCK period.
- `sendData`  out  8  next response byte, sampled by the serial slave.
- `delays`  out  NUM_CH*DELAY_W  active bank; channel i is at `[i*DELAY_W +: DELAY_W]`.
- `update`  out  1  one-CLK pulse when the active bank is reloaded.
- `frame_err`  out  1  one-CLK pulse on a timeout abort.

## Operation
**Byte capture**
- `recieved` passes through a 2-FF synchronizer plus one edge-detect FF.
- On a detected rising edge, `recievedData` is captured and the byte is processed.

**Command byte**
- Bit7 = W, bit6 = U, bits[5:0] = channel address A.
- `00`: read. 4-byte frame (cmd plus 3 don't-care bytes). States IDLE -> RD_1 -> RD_2 -> RD_3 -> IDLE.
- `10`: write. 3-byte frame (cmd, hi, lo). States IDLE -> WR_HI -> WR_LO -> IDLE.
- `11`: write, then update once the write has committed.
- `01`: update only. Single byte; the state stays IDLE.

**Write**
- Shadow[A] <= {hi[DELAY_W-9:0], lo} on the lo byte.
- Upper bits of the hi byte are ignored.
- If A >= NUM_CH, nothing is written, but the frame is still consumed.

**Update**
- All active registers <= shadow registers.
- `update` pulses in the same cycle as the load.

**Read-back**
- The slave loads `sendData` at the start of the next byte, before the decoder has seen the current byte. A value set after byte k therefore shifts out in byte k+2.
- After the cmd byte: `sendData` = shadow[A] high byte, zero-extended.
- After RD_1: `sendData` = shadow[A][7:0].
- After RD_2: `sendData` = 0x00.
- If A >= NUM_CH, the read returns 0x00 0x00.

**Timeout**
- The idle counter clears on every byte and saturates.
- If the counter reaches TIMEOUT in any non-IDLE state:
  - state -> IDLE;
  - the pending write is discarded and no update occurs;
  - `sendData` <= 0x00;
  - `frame_err` pulses.

**Reset**
- Values on reset:
  - state IDLE;
  - both banks 0, so `delays` = 0;
  - `sendData` = 0x00;
  - `update` = 0, `frame_err` = 0;
  - synchronizer FFs 0;
  - counter 0.
- Mid-frame reset abandons the frame. The next byte after release is treated as a command.

## Timing
**Byte detection**
- SCK high time must be >= 3 CLK periods.
- SCK period must be >= 8 CLK periods.

**Latency from `recieved` rising at the CLK input**
- Byte detected at cycle 3 (±1 for sync phase).
- State and `sendData` change at cycle 3.
- Shadow commit at cycle 3 of the lo byte.
- For `11` commands, the active load and `update` pulse occur at cycle 4.
- `01` update: active load and `update` at cycle 3.

**Simultaneous events**
- A byte detected in the same cycle the counter hits TIMEOUT is processed, and the timeout is suppressed.
- An update never coincides with a shadow write.

**Per-byte limit**
- At most one byte is processed per `recieved` pulse.
- Held-high glitches are ignored.

## Test plan
- Reset, no bytes -> `delays` = 0, `sendData` = 0x00, `update` and `frame_err` stay 0 for 2*TIMEOUT cycles.
- Bytes 0x83, 0x0A, 0xBC -> shadow[3] = 0xABC. `delays` unchanged until byte 0x43. Then `update` pulses once and channel 3 of `delays` = 0xABC.
- After the write above, bytes 0x03, 0x00, 0x00, 0x00 -> the slave shifts out 0x0A in byte 3 and 0xBC in byte 4. `sendData` returns to 0x00.
- Bytes 0xC5, 0xFF, 0x12 -> channel 5 = 0xF12 (upper hi bits masked). `update` pulses 1 CLK after the commit.
- Byte 0x87, then silence for TIMEOUT cycles -> `frame_err` pulses. Following bytes 0x45 are treated as a command, so `update` pulses and shadow[7] is unchanged.
- Write to A = 0x3F with NUM_CH = 16 -> no register changes. A read of 0x3F returns 0x00 0x00. A `res_n` pulse mid-frame -> all outputs at reset values.
